// File: rtl/bt_resp_rx.sv
// UART 8N1 receiver plus line assembler for BT module responses ("AOK"/"ERR" lines).
// Optional idle timeout on partial lines is enabled by defining BT_RESP_TIMEOUT_EN.
module bt_resp_rx #(
  parameter int         BAUD_DIV   = 2604,
  parameter logic [7:0] TERM       = 8'h0A,
  parameter int         TMO_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_resp,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       resp_rcvd,
  output logic       resp_ok,
  output logic       resp_err,
  output logic [4:0] resp_len,
  output logic       ovfl,
  output logic       resp_tmo
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t r_state, w_next;

  logic          r_rx_s1, r_rx_s2, r_rx_d;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift, r_rx_byte;
  logic          r_rx_rdy, r_frm_err;
  logic          w_fall, w_half, w_full, w_adv, w_byte_ok, w_frm;
  logic          w_tmo;

  // Third flop only feeds edge detection; sampling uses r_rx_s2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s2;
  assign w_half = (r_baud == HALF);
  assign w_full = (r_baud == FULL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: if (w_half) w_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_full && r_bit == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_full) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adv     = 1'b0;
    w_byte_ok = 1'b0;
    w_frm     = 1'b0;
    case (r_state)
      S_START: w_adv = w_half;
      S_DATA:  w_adv = w_full;
      S_STOP: begin
        w_adv     = w_full;
        w_byte_ok = w_full & r_rx_s2;
        w_frm     = w_full & ~r_rx_s2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx_byte <= '0;
      r_rx_rdy  <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_baud    <= (r_state == S_IDLE || w_adv) ? '0 : r_baud + 1'b1;
      r_rx_rdy  <= w_byte_ok;
      r_frm_err <= w_frm;
      if (r_state == S_IDLE) r_bit <= '0;
      if (r_state == S_DATA && w_full) begin
        r_shift <= {r_rx_s2, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
      if (w_byte_ok) r_rx_byte <= r_shift;
    end
  end

  // Line assembler
  logic [7:0] r_buf [16];
  logic [4:0] r_cnt, r_resp_len;
  logic       r_resp_rcvd, r_resp_ok, r_resp_err, r_ovfl;
  logic       w_is_term, w_is_data, w_wr, w_aok, w_errl;

  assign w_is_term = r_rx_rdy && (r_rx_byte == TERM);
  assign w_is_data = r_rx_rdy && (r_rx_byte != TERM) && (r_rx_byte != 8'h0D);
  assign w_wr      = w_is_data && (r_cnt != 5'd16);
  assign w_aok  = (r_cnt >= 5'd3) && r_buf[0] == 8'h41 && r_buf[1] == 8'h4F && r_buf[2] == 8'h4B;
  assign w_errl = (r_cnt >= 5'd3) && r_buf[0] == 8'h45 && r_buf[1] == 8'h52 && r_buf[2] == 8'h52;

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_cnt[3:0]] <= r_rx_byte;
  end

  // Later assignments win: a line completion overrides a coincident clr_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_resp_len  <= '0;
      r_resp_rcvd <= 1'b0;
      r_resp_ok   <= 1'b0;
      r_resp_err  <= 1'b0;
      r_ovfl      <= 1'b0;
    end else begin
      r_resp_rcvd <= 1'b0;
      if (clr_resp) begin
        r_resp_ok  <= 1'b0;
        r_resp_err <= 1'b0;
        r_ovfl     <= 1'b0;
      end
      if (w_tmo) r_cnt <= '0;
      if (w_wr) r_cnt <= r_cnt + 1'b1;
      if (w_is_data && r_cnt == 5'd16) r_ovfl <= 1'b1;
      if (w_is_term && r_cnt != 5'd0) begin
        r_resp_rcvd <= 1'b1;
        r_resp_len  <= r_cnt;
        r_resp_ok   <= w_aok;
        r_resp_err  <= w_errl;
        r_cnt       <= '0;
      end
    end
  end

`ifdef BT_RESP_TIMEOUT_EN
  logic [31:0] r_idle;
  logic        r_resp_tmo, w_run;

  assign w_run = (r_cnt != 5'd0) && (r_state == S_IDLE);
  assign w_tmo = w_run && !r_rx_rdy && (r_idle == 32'(TMO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle     <= '0;
      r_resp_tmo <= 1'b0;
    end else begin
      r_resp_tmo <= w_tmo;
      if ((r_state == S_IDLE && w_fall) || !w_run || w_tmo) r_idle <= '0;
      else                                                  r_idle <= r_idle + 1'b1;
    end
  end
  assign resp_tmo = r_resp_tmo;
`else
  assign w_tmo    = 1'b0;
  assign resp_tmo = 1'b0;
`endif

  assign rx_byte   = r_rx_byte;
  assign rx_rdy    = r_rx_rdy;
  assign frm_err   = r_frm_err;
  assign resp_rcvd = r_resp_rcvd;
  assign resp_ok   = r_resp_ok;
  assign resp_err  = r_resp_err;
  assign resp_len  = r_resp_len;
  assign ovfl      = r_ovfl;
endmodule

// File: tb/tb_bt_resp_rx.sv
// Scoreboard bench for bt_resp_rx: bytes and completed lines are queued as sent and
// checked as rx_rdy / resp_rcvd appear.
module tb_bt_resp_rx;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst, RX, clr_resp;
  logic [7:0] rx_byte;
  logic       rx_rdy, frm_err, resp_rcvd, resp_ok, resp_err, ovfl, resp_tmo;
  logic [4:0] resp_len;

  bt_resp_rx #(.BAUD_DIV(BD), .TERM(8'h0A), .TMO_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_resp(clr_resp),
    .rx_byte(rx_byte), .rx_rdy(rx_rdy), .frm_err(frm_err), .resp_rcvd(resp_rcvd),
    .resp_ok(resp_ok), .resp_err(resp_err), .resp_len(resp_len), .ovfl(ovfl),
    .resp_tmo(resp_tmo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_rdy = 0, n_rcvd = 0, n_frm = 0, n_tmo = 0;
  logic [7:0] q_byte [$];
  logic [6:0] q_line [$];   // {len, ok, err}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_rdy) begin
        n_rdy++;
        if (q_byte.size() != 0) chk("rx_byte", {24'd0, rx_byte}, {24'd0, q_byte.pop_front()});
        else chk("unexp_rdy", {31'd0, rx_rdy}, 32'd0);
      end
      if (resp_rcvd) begin
        n_rcvd++;
        if (q_line.size() != 0) chk("line", {25'd0, resp_len, resp_ok, resp_err}, {25'd0, q_line.pop_front()});
        else chk("unexp_rcvd", {31'd0, resp_rcvd}, 32'd0);
      end
      if (frm_err)  n_frm++;
      if (resp_tmo) n_tmo++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD / 2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      q_byte.push_back(s[i]);
      send_byte(s[i], 1'b1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_resp = 1'b1;
    @(negedge clk);
    clr_resp = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int r0, c0, f0, t0;

  initial begin
    rst = 1'b1; RX = 1'b1; clr_resp = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_flags", {25'd0, rx_rdy, frm_err, resp_rcvd, resp_ok, resp_err, ovfl, resp_tmo}, 32'd0);
    chk("rst_len", {27'd0, resp_len}, 32'd0);

    // AOK CR LF
    r0 = n_rdy; c0 = n_rcvd;
    q_line.push_back({5'd3, 1'b1, 1'b0});
    send_str("AOK\r\n");
    chk("aok_rdy_cnt", n_rdy - r0, 5);
    chk("aok_rcvd_cnt", n_rcvd - c0, 1);
    chk("aok_ok", {31'd0, resp_ok}, 1);
    chk("aok_err", {31'd0, resp_err}, 0);
    chk("aok_len", {27'd0, resp_len}, 3);

    // ERR CR LF then clear
    q_line.push_back({5'd3, 1'b0, 1'b1});
    send_str("ERR\r\n");
    chk("err_err", {31'd0, resp_err}, 1);
    chk("err_ok", {31'd0, resp_ok}, 0);
    pulse_clr();
    chk("clr_err", {31'd0, resp_err}, 0);
    chk("clr_len", {27'd0, resp_len}, 3);

    // framing error in mid-line must not disturb the partial line
    send_str("A");
    r0 = n_rdy; f0 = n_frm;
    send_byte(8'h55, 1'b0);
    repeat (BD) @(negedge clk);
    chk("frm_cnt", n_frm - f0, 1);
    chk("frm_no_rdy", n_rdy - r0, 0);
    chk("frm_keep_byte", {24'd0, rx_byte}, 32'h41);

    // short low glitch: false start, nothing out
    r0 = n_rdy; f0 = n_frm;
    RX = 1'b0;
    repeat (BD / 2 - 3) @(negedge clk);
    RX = 1'b1;
    repeat (BD * 12) @(negedge clk);
    chk("glitch_rdy", n_rdy - r0, 0);
    chk("glitch_frm", n_frm - f0, 0);

    q_line.push_back({5'd3, 1'b1, 1'b0});
    send_str("OK\n");
    chk("frm_line_ok", {31'd0, resp_ok}, 1);

    // overflow
    c0 = n_rcvd;
    q_line.push_back({5'd16, 1'b0, 1'b0});
    send_str("AAAAAAAAAAAAAAAAAAAA\n");
    chk("ovf_flag", {31'd0, ovfl}, 1);
    chk("ovf_len", {27'd0, resp_len}, 16);
    chk("ovf_ok", {31'd0, resp_ok}, 0);
    chk("ovf_rcvd", n_rcvd - c0, 1);
    pulse_clr();
    chk("ovf_clr", {31'd0, ovfl}, 0);

    // short line and empty CR-LF
    q_line.push_back({5'd3, 1'b1, 1'b0});
    send_str("AOK\n");
    c0 = n_rcvd;
    q_line.push_back({5'd2, 1'b0, 1'b0});
    send_str("AO\n");
    send_str("\r\n");
    chk("short_ok", {31'd0, resp_ok}, 0);
    chk("short_len", {27'd0, resp_len}, 2);
    chk("short_rcvd", n_rcvd - c0, 1);

    // reset mid-line and mid-byte
    send_str("AO");
    RX = 1'b0;
    repeat (BD * 3) @(negedge clk);
    rst = 1'b1; RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_byte", {24'd0, rx_byte}, 0);
    q_line.push_back({5'd1, 1'b0, 1'b0});
    send_str("K\n");
    chk("rst_line_len", {27'd0, resp_len}, 1);
    chk("rst_line_ok", {31'd0, resp_ok}, 0);

    // idle partial line
    c0 = n_rcvd; t0 = n_tmo;
    send_str("AO");
    repeat (1200) @(negedge clk);
    chk("idle_rcvd", n_rcvd - c0, 0);
`ifdef BT_RESP_TIMEOUT_EN
    chk("tmo_cnt", n_tmo - t0, 1);
    q_line.push_back({5'd3, 1'b1, 1'b0});
    send_str("AOK\n");
`else
    chk("tmo_none", n_tmo - t0, 0);
    q_line.push_back({5'd3, 1'b1, 1'b0});
    send_str("K\n");
`endif
    chk("idle_ok", {31'd0, resp_ok}, 1);
    chk("idle_len", {27'd0, resp_len}, 3);

    repeat (10) @(negedge clk);
    chk("q_byte_empty", q_byte.size(), 0);
    chk("q_line_empty", q_line.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
